alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single two-stage ALU between two requesters, e.g. the execute stage (req0) and the address-generation/CSR helper (req1).
- Arbitrates round-robin and drives the ALU operand and function ports.
- Tracks the one in-flight operation and returns each result to its owner through a per-requester response FIFO with valid/ready handshakes.
- Sits beside the ALU in the execute unit; the ALU itself is instantiated by the parent, not inside this block.

Parameters:
- RSP_DEPTH, 2, entries in each requester's response FIFO (power of two, at least 2).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  32 each  operands
- req0_func  in  3  ALU function select
- req0_mod  in  1  ALU function modifier
- req1_valid, req1_ready, req1_a, req1_b, req1_func, req1_mod  same as req0, for requester 1
- rsp0_valid  out  1  result available for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  32  result for requester 0
- rsp1_valid, rsp1_ready, rsp1_result  same as rsp0, for requester 1
- alu_a, alu_b  out  32 each  to ALU input_a/input_b
- alu_func  out  3  to ALU function_select
- alu_mod  out  1  to ALU function_modifier
- alu_result  in  32  from ALU result, valid the cycle after issue
- busy  out  1  in-flight op or any non-empty response FIFO

Behaviour:
- Reset (async assert, sync deassert in parent):
  - all FIFOs empty; rsp*_valid=0, rsp*_result=0
  - in-flight valid=0
  - round-robin pointer=0; busy=0
- Credit rule for requester i: eligible_i = reqi_valid && (occupancy_i + inflight_for_i < RSP_DEPTH).
  - occupancy_i is the registered count; a same-cycle pop does not add credit. This keeps req ready off the rsp ready path.
- Grant, combinational:
  - if exactly one requester is eligible, grant it;
  - if both are eligible, grant the one the pointer names;
  - reqi_ready = grant_i.
  - At most one grant per cycle.
- Pointer update: on any grant, the pointer moves to the other requester. With no grant it holds.
- ALU drive: alu_* = operands, func and mod of the granted requester. With no grant, all alu_* = 0. The ALU samples its inputs at the end of the grant cycle.
- In-flight stage, registered:
  - inflight_valid <= any grant; inflight_id <= granted index.
  - Cycle N+1 after a grant in cycle N: alu_result is valid and is pushed into FIFO[inflight_id] at the end of N+1.
- Latency: grant in cycle N gives rsp_valid in cycle N+2 (FIFO empty case). Throughput is 1 op/cycle total.
- FIFO:
  - rspi_valid = !empty; rspi_result = head entry (0 when empty).
  - Pop on rspi_valid && rspi_ready.
  - Push and pop in the same cycle keep occupancy and preserve order.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by the credit rule; the bench asserts this.
- Per requester, results return in issue order. There is no ordering between requesters.
- Reset mid-operation: the in-flight op and FIFO contents are discarded; no response is produced for them.
- alu_result is ignored whenever inflight_valid=0, since ALU state after reset is undefined.
- busy = inflight_valid || !empty0 || !empty1.

Decomposition:
- Shared package alu_pkg:
  - ALU function-code constants (ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND_CLR=111)
  - a requester-index type
  - the response-count width function log2(RSP_DEPTH)+1
- One sub-module, alu_rsp_fifo: sync FIFO with occupancy output, instantiated twice.
- Arbiter and in-flight logic stay in the top.

Test Plan:
- Single op: req0 ADD a=5 b=7 mod=0, rsp0_ready=1.
  -> req0_ready=1 in cycle N; rsp0_valid with result 0x0000000C in cycle N+2, for 1 cycle.
- Subtract and shift on req1: SUB 3-5 -> 0xFFFFFFFE; SRA a=0x80000000 b=4 mod=1 -> 0xF8000000; both in order, 2-cycle latency each.
- Contention: both valid every cycle, ready held high.
  -> grants alternate 0,1,0,1 starting with req0 after reset; each side sees 1 result every 2 cycles with correct values.
- Backpressure: rsp0_ready=0, req0 issues ADD 1+1, 2+2, 3+3.
  -> only 2 accepted (RSP_DEPTH=2); req0_ready=0 thereafter; req1 still served.
  -> raising rsp0_ready yields 2, 4, then the third op accepted, giving 6.
- Simultaneous push/pop with a full FIFO: occupancy stays 2, no loss or duplication, order kept.
- Reset mid-op: assert rst_n=0 the cycle after a grant.
  -> rsp*_valid=0 and busy=0 immediately; after release no stale response; the first new op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: function codes, requester id type
// and the response-count width helper.
package alu_pkg;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND_CLR = 3'b111;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_id_e;

  // Width able to hold an occupancy of 0..depth inclusive.
  function automatic int rsp_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Per-requester response FIFO: synchronous, power-of-two depth, exposes its
// registered occupancy so the arbiter can compute credits.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = rsp_cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [31:0]   push_data_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [31:0]   head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, tracking the
// single in-flight op and steering its result into the owner's response FIFO.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_func,
  input  logic        req0_mod,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_func,
  input  logic        req1_mod,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_func,
  output logic        alu_mod,
  input  logic [31:0] alu_result,
  output logic        busy
);

  localparam int CW = rsp_cnt_width(RSP_DEPTH);
  localparam logic [CW-1:0] CREDITS = CW'(RSP_DEPTH);

  req_id_e rr_ptr_q, rr_ptr_d;
  req_id_e inflight_id_q, inflight_id_d;
  logic    inflight_valid_q;

  logic [CW-1:0] cnt0, cnt1;
  logic          empty0, empty1;
  logic [31:0]   head0, head1;
  logic          inflight0, inflight1;
  logic [CW-1:0] need0, need1;
  logic          elig0, elig1;
  logic          grant0, grant1, any_grant;
  logic          push0, push1, pop0, pop1;

  assign inflight0 = inflight_valid_q && (inflight_id_q == REQ_0);
  assign inflight1 = inflight_valid_q && (inflight_id_q == REQ_1);

  // Credits use the registered count only, so req ready never depends on rsp ready.
  assign need0 = cnt0 + CW'(inflight0);
  assign need1 = cnt1 + CW'(inflight1);
  assign elig0 = req0_valid && (need0 < CREDITS);
  assign elig1 = req1_valid && (need1 < CREDITS);

  always_comb begin
    grant0 = elig0;
    grant1 = elig1;
    if (elig0 && elig1) begin
      grant0 = (rr_ptr_q == REQ_0);
      grant1 = (rr_ptr_q == REQ_1);
    end
  end

  assign any_grant  = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_func = '0;
    alu_mod  = 1'b0;
    if (grant0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_func = req0_func;
      alu_mod  = req0_mod;
    end else if (grant1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_func = req1_func;
      alu_mod  = req1_mod;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant0)      rr_ptr_d = REQ_1;
    else if (grant1) rr_ptr_d = REQ_0;
    inflight_id_d = grant1 ? REQ_1 : REQ_0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q         <= REQ_0;
      inflight_valid_q <= 1'b0;
      inflight_id_q    <= REQ_0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      inflight_valid_q <= any_grant;
      inflight_id_q    <= inflight_id_d;
    end
  end

  assign push0 = inflight0;
  assign push1 = inflight1;
  assign pop0  = rsp0_valid && rsp0_ready;
  assign pop1  = rsp1_valid && rsp1_ready;

  alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .CW(CW)) u_fifo0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push0),
    .push_data_i (alu_result),
    .pop_i       (pop0),
    .empty_o     (empty0),
    .count_o     (cnt0),
    .head_o      (head0)
  );

  alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .CW(CW)) u_fifo1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push1),
    .push_data_i (alu_result),
    .pop_i       (pop1),
    .empty_o     (empty1),
    .count_o     (cnt1),
    .head_o      (head1)
  );

  assign rsp0_valid  = !empty0;
  assign rsp0_result = head0;
  assign rsp1_valid  = !empty1;
  assign rsp1_result = head1;

  assign busy = inflight_valid_q || !empty0 || !empty1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-cycle vector table plus hand sequences
// for streaming under backpressure and reset with work in flight.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int RSP_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_mod;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_func;
  logic        req1_valid, req1_ready, req1_mod;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_func;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_func;
  logic        alu_mod;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func(req0_func), .req0_mod(req0_mod),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func(req1_func), .req1_mod(req1_mod),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_mod(alu_mod),
    .alu_result(alu_result), .busy(busy)
  );

  // Reference ALU: one register stage, result valid the cycle after issue.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic m);
    case (f)
      ALU_ADD_SUB: return m ? a - b : a + b;
      ALU_SLL:     return a << b[4:0];
      ALU_SLT:     return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:    return {31'b0, a < b};
      ALU_XOR:     return a ^ b;
      ALU_SRL_SRA: return m ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      ALU_OR:      return a | b;
      default:     return m ? (a & ~b) : (a & b);
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_ref(alu_a, alu_b, alu_func, alu_mod);

  always @(negedge clk) begin
    if (rst_n && dut.u_fifo0.push_i && !dut.u_fifo0.pop_i && dut.u_fifo0.count_o == 2) ovf_cnt++;
    if (rst_n && dut.u_fifo1.push_i && !dut.u_fifo1.pop_i && dut.u_fifo1.count_o == 2) ovf_cnt++;
  end

  typedef struct {
    logic v0; logic [2:0] f0; logic m0; logic [31:0] a0, b0;
    logic v1; logic [2:0] f1; logic m1; logic [31:0] a1, b1;
    logic r0, r1;
    logic e_rdy0, e_rdy1;
    logic e_v0; logic [31:0] e_res0;
    logic e_v1; logic [31:0] e_res1;
    logic e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(logic v0, logic [2:0] f0, logic m0, logic [31:0] a0, logic [31:0] b0,
                             logic v1, logic [2:0] f1, logic m1, logic [31:0] a1, logic [31:0] b1,
                             logic r0, logic r1, logic e_rdy0, logic e_rdy1,
                             logic e_v0, logic [31:0] e_res0, logic e_v1, logic [31:0] e_res1,
                             logic e_busy);
    vec_t t;
    t.v0 = v0; t.f0 = f0; t.m0 = m0; t.a0 = a0; t.b0 = b0;
    t.v1 = v1; t.f1 = f1; t.m1 = m1; t.a1 = a1; t.b1 = b1;
    t.r0 = r0; t.r1 = r1; t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1;
    t.e_v0 = e_v0; t.e_res0 = e_res0; t.e_v1 = e_v1; t.e_res1 = e_res1; t.e_busy = e_busy;
    return t;
  endfunction

  function automatic vec_t I(logic r0, logic r1, logic e_v0, logic [31:0] e_res0,
                             logic e_v1, logic [31:0] e_res1, logic e_busy);
    return V(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, r0, r1, 0, 0, e_v0, e_res0, e_v1, e_res1, e_busy);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_func = 0; req0_mod = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_func = 0; req1_mod = 0;
  endtask

  task automatic apply(input vec_t t);
    req0_valid = t.v0; req0_func = t.f0; req0_mod = t.m0; req0_a = t.a0; req0_b = t.b0;
    req1_valid = t.v1; req1_func = t.f1; req1_mod = t.m1; req1_a = t.a1; req1_b = t.b1;
    rsp0_ready = t.r0; rsp1_ready = t.r1;
  endtask

  task automatic check_vec(input int i, input vec_t t);
    logic [31:0] ea, eb;
    logic [2:0]  ef;
    logic        em;
    ea = 0; eb = 0; ef = 0; em = 0;
    if (t.e_rdy0) begin ea = t.a0; eb = t.b0; ef = t.f0; em = t.m0; end
    else if (t.e_rdy1) begin ea = t.a1; eb = t.b1; ef = t.f1; em = t.m1; end
    chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(t.e_rdy0));
    chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(t.e_rdy1));
    chk($sformatf("v%0d rsp0_valid", i), 32'(rsp0_valid), 32'(t.e_v0));
    chk($sformatf("v%0d rsp0_result", i), rsp0_result, t.e_res0);
    chk($sformatf("v%0d rsp1_valid", i), 32'(rsp1_valid), 32'(t.e_v1));
    chk($sformatf("v%0d rsp1_result", i), rsp1_result, t.e_res1);
    chk($sformatf("v%0d busy", i), 32'(busy), 32'(t.e_busy));
    chk($sformatf("v%0d alu_a", i), alu_a, ea);
    chk($sformatf("v%0d alu_b", i), alu_b, eb);
    chk($sformatf("v%0d alu_func", i), 32'(alu_func), 32'(ef));
    chk($sformatf("v%0d alu_mod", i), 32'(alu_mod), 32'(em));
  endtask

  initial begin
    int issued, got, cyc;
    rst_n = 0;
    idle_inputs();
    rsp0_ready = 1; rsp1_ready = 1;

    // single op, req1 SUB/SRA, contention, backpressure
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 5, 7, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(I(1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(I(1, 1, 1, 32'h0000000C, 0, 0, 1));
    vecs.push_back(I(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, ALU_ADD_SUB, 1, 3, 5, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, ALU_SRL_SRA, 1, 32'h80000000, 4, 1, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(I(1, 1, 0, 0, 1, 32'hFFFFFFFE, 1));
    vecs.push_back(I(1, 1, 0, 0, 1, 32'hF8000000, 1));
    vecs.push_back(I(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 10, 1, 1, ALU_OR, 0, 32'h100, 32'h011, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, ALU_XOR, 0, 32'hF0F0, 32'h0FF0, 1, ALU_OR, 0, 32'h100, 32'h011, 1, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(V(1, ALU_XOR, 0, 32'hF0F0, 32'h0FF0, 1, ALU_AND_CLR, 1, 32'hFF, 32'h0F, 1, 1, 1, 0, 1, 32'hB, 0, 0, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, ALU_AND_CLR, 1, 32'hFF, 32'h0F, 1, 1, 0, 1, 0, 0, 1, 32'h111, 1));
    vecs.push_back(I(1, 1, 1, 32'hFF00, 0, 0, 1));
    vecs.push_back(I(1, 1, 0, 0, 1, 32'hF0, 1));
    vecs.push_back(I(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 2, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 3, 3, 1, ALU_ADD_SUB, 0, 100, 1, 0, 1, 0, 1, 1, 2, 0, 0, 1));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 1, 32'h65, 1));
    vecs.push_back(V(1, ALU_ADD_SUB, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 4, 0, 0, 1));
    vecs.push_back(I(1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(I(1, 1, 1, 6, 0, 0, 1));
    vecs.push_back(I(1, 1, 0, 0, 0, 0, 0));

    #12;
    chk("reset rsp0_valid", 32'(rsp0_valid), 0);
    chk("reset rsp1_valid", 32'(rsp1_valid), 0);
    chk("reset rsp0_result", rsp0_result, 0);
    chk("reset rsp1_result", rsp1_result, 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
    end

    // Streaming with intermittent rsp backpressure: order kept, no loss/dup.
    issued = 0; got = 0; cyc = 0;
    idle_inputs();
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      req0_valid = (issued < 8);
      req0_a     = 32'(issued + 1);
      req0_b     = 100;
      req0_func  = ALU_ADD_SUB;
      req0_mod   = 0;
      rsp0_ready = (cyc % 5) >= 2;
      @(negedge clk);
      if (req0_ready) issued++;
      if (rsp0_valid && rsp0_ready) begin
        chk($sformatf("stream result %0d", got), rsp0_result, 32'(got + 101));
        got++;
      end
      cyc++;
    end
    chk("stream count", 32'(got), 8);
    @(posedge clk); #1;
    idle_inputs();
    rsp0_ready = 1;
    repeat (3) @(negedge clk);
    chk("stream drained rsp0_valid", 32'(rsp0_valid), 0);
    chk("stream drained busy", 32'(busy), 0);

    // Reset with a stale FIFO entry and an op in flight.
    @(posedge clk); #1;
    rsp1_ready = 0;
    req1_valid = 1; req1_func = ALU_OR; req1_a = 1; req1_b = 2;
    @(negedge clk);
    chk("pre-reset req1_ready", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_func = ALU_ADD_SUB; req0_mod = 0; req0_a = 7; req0_b = 8;
    @(negedge clk);
    chk("pre-reset req0_ready", 32'(req0_ready), 1);
    @(posedge clk); #1;
    idle_inputs();
    chk("pre-reset rsp1_valid", 32'(rsp1_valid), 1);
    rst_n = 0;
    #1;
    chk("mid-reset rsp0_valid", 32'(rsp0_valid), 0);
    chk("mid-reset rsp1_valid", 32'(rsp1_valid), 0);
    chk("mid-reset rsp1_result", rsp1_result, 0);
    chk("mid-reset busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset rsp0_valid %0d", k), 32'(rsp0_valid), 0);
      chk($sformatf("post-reset rsp1_valid %0d", k), 32'(rsp1_valid), 0);
      chk($sformatf("post-reset busy %0d", k), 32'(busy), 0);
    end

    // Fresh contention after reset: pointer starts at req0.
    @(posedge clk); #1;
    rsp1_ready = 1;
    req0_valid = 1; req0_func = ALU_SLT; req0_mod = 0; req0_a = 32'hFFFFFFFF; req0_b = 1;
    req1_valid = 1; req1_func = ALU_SLL; req1_mod = 0; req1_a = 1; req1_b = 4;
    @(negedge clk);
    chk("after-reset grant0 req0_ready", 32'(req0_ready), 1);
    chk("after-reset grant0 req1_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("after-reset grant1 req1_ready", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk);
    chk("after-reset rsp0_valid", 32'(rsp0_valid), 1);
    chk("after-reset rsp0_result", rsp0_result, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after-reset rsp1_valid", 32'(rsp1_valid), 1);
    chk("after-reset rsp1_result", rsp1_result, 32'h10);
    chk("after-reset rsp0 single beat", 32'(rsp0_valid), 0);

    chk("fifo overflow events", 32'(ovf_cnt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
